// File: rtl/oc_bank_arbiter.sv
// Operand-collector read-port arbiter for 4 register-file banks, with one-cycle tag pipeline.
// Define OC_ARB_RR_EN for per-bank round-robin; default build uses fixed lowest-slot priority.
module oc_bank_arbiter #(
   parameter int NUM_OC = 4,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2*NUM_OC-1:0]   req,
   input  logic [10*NUM_OC-1:0]  req_reg_id,
   input  logic [NUM_OC-1:0]     oc_clr,
   input  logic [3:0]            wb_bank_busy,
   output logic [2*NUM_OC-1:0]   gnt,
   output logic [3:0]            bk_rd_en,
   output logic [11:0]           bk_rd_addr,
   output logic [11:0]           bk_ocid,
   output logic [3:0]            bk_vld,
   output logic [3:0]            bk_bz,
   output logic [4*CNT_W-1:0]    conflict_cnt
);

   localparam int NS   = 2 * NUM_OC;
   // Tag fields are 3 bits wide, so at most 8 slots (NUM_OC <= 4).
   localparam int ID_W = 3;

   logic [3:0][NS-1:0] gnt_bank;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         logic [NS-1:0]    elig;
         logic             found;
         logic             grant;
         logic             multi;
         logic [ID_W-1:0]  win;
         logic [2:0]       win_row;
         logic             vld_reg;
         logic             bz_reg;
         logic [ID_W-1:0]  ocid_reg;
         logic [CNT_W-1:0] cnt_reg;

         always_comb begin
            elig = '0;
            for (int s = 0; s < NS; s++) begin
               elig[s] = req[s] & ~oc_clr[s/2] & (req_reg_id[5*s+3 +: 2] == 2'(gi));
            end
         end

`ifdef OC_ARB_RR_EN
         logic [ID_W-1:0] ptr_reg;

         always_comb begin
            found   = 1'b0;
            win     = '0;
            win_row = '0;
            for (int k = 0; k < NS; k++) begin
               int idx;
               idx = (int'(ptr_reg) + k) % NS;
               if (!found && elig[idx]) begin
                  found   = 1'b1;
                  win     = ID_W'(idx);
                  win_row = req_reg_id[5*idx +: 3];
               end
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ptr_reg <= '0;
            end else if (grant) begin
               ptr_reg <= ID_W'((int'(win) + 1) % NS);
            end
         end
`else
         // Descending scan so the lowest eligible slot is the last one written.
         always_comb begin
            found   = 1'b0;
            win     = '0;
            win_row = '0;
            for (int s = NS - 1; s >= 0; s--) begin
               if (elig[s]) begin
                  found   = 1'b1;
                  win     = ID_W'(s);
                  win_row = req_reg_id[5*s +: 3];
               end
            end
         end
`endif

         assign grant = found & ~wb_bank_busy[gi];
         // Two or more bits set: clearing the lowest set bit leaves something.
         assign multi = |(elig & (elig - NS'(1)));

         assign gnt_bank[gi]          = grant ? (NS'(1) << win) : '0;
         assign bk_rd_en[gi]          = grant;
         assign bk_rd_addr[3*gi +: 3] = grant ? win_row : 3'd0;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               vld_reg  <= 1'b0;
               bz_reg   <= 1'b0;
               ocid_reg <= '0;
               cnt_reg  <= '0;
            end else begin
               vld_reg <= grant;
               bz_reg  <= wb_bank_busy[gi] & found;
               if (grant) begin
                  ocid_reg <= win;
               end
               if (multi && (cnt_reg != {CNT_W{1'b1}})) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         end

         assign bk_vld[gi]                    = vld_reg;
         assign bk_bz[gi]                     = bz_reg;
         assign bk_ocid[3*gi +: 3]            = ocid_reg;
         assign conflict_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
      end
   endgenerate

   always_comb begin
      gnt = gnt_bank[0] | gnt_bank[1] | gnt_bank[2] | gnt_bank[3];
   end

endmodule

// File: tb/tb_oc_bank_arbiter.sv
// Directed bench for oc_bank_arbiter; expectations follow OC_ARB_RR_EN if it is defined.
module tb_oc_bank_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  req = '0;
   logic [39:0] req_reg_id = '0;
   logic [3:0]  oc_clr = '0;
   logic [3:0]  wb_bank_busy = '0;
   logic [7:0]  gnt;
   logic [3:0]  bk_rd_en;
   logic [11:0] bk_rd_addr;
   logic [11:0] bk_ocid;
   logic [3:0]  bk_vld;
   logic [3:0]  bk_bz;
   logic [63:0] conflict_cnt;

   int total = 0;
   int bad   = 0;

   oc_bank_arbiter #(.NUM_OC(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req(req), .req_reg_id(req_reg_id), .oc_clr(oc_clr),
      .wb_bank_busy(wb_bank_busy), .gnt(gnt), .bk_rd_en(bk_rd_en), .bk_rd_addr(bk_rd_addr),
      .bk_ocid(bk_ocid), .bk_vld(bk_vld), .bk_bz(bk_bz), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic set_slot(input int s, input logic [1:0] b, input logic [2:0] r);
      req_reg_id[5*s +: 5] = {b, r};
   endtask

   task automatic do_reset();
      req = '0; oc_clr = '0; wb_bank_busy = '0; req_reg_id = '0;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req = 8'hFF;
      for (int s = 0; s < 8; s++) set_slot(s, 2'(s % 4), 3'(s));
      @(posedge clk); #1;
      total++; if (bk_vld !== 4'h0) begin bad++; $display("FAIL reset_vld: got %h want 0", bk_vld); end
      total++; if (bk_bz !== 4'h0) begin bad++; $display("FAIL reset_bz: got %h want 0", bk_bz); end
      total++; if (conflict_cnt !== 64'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0", conflict_cnt); end
      total++; if (bk_ocid !== 12'h0) begin bad++; $display("FAIL reset_ocid: got %h want 0", bk_ocid); end
      rst = 1'b1;
      #1;
      total++; if (gnt !== 8'h0F) begin bad++; $display("FAIL reset_first_gnt: got %h want 0f", gnt); end
      @(posedge clk); #1;
      total++; if (bk_vld !== 4'hF) begin bad++; $display("FAIL reset_first_vld: got %h want f", bk_vld); end
      total++; if (bk_ocid !== 12'h688) begin bad++; $display("FAIL reset_first_ocid: got %h want 688", bk_ocid); end
      total++; if (conflict_cnt !== {16'd1, 16'd1, 16'd1, 16'd1}) begin
         bad++; $display("FAIL reset_first_cnt: got %h want 0001000100010001", conflict_cnt);
      end
      req = '0;
      $display("test_reset done");
   endtask

   task automatic test_single_read();
      do_reset();
      set_slot(3, 2'd2, 3'd5);
      req = 8'h08;
      #1;
      total++; if (gnt !== 8'h08) begin bad++; $display("FAIL single_gnt: got %h want 08", gnt); end
      total++; if (bk_rd_en !== 4'b0100) begin bad++; $display("FAIL single_rd_en: got %b want 0100", bk_rd_en); end
      total++; if (bk_rd_addr !== 12'h140) begin bad++; $display("FAIL single_addr: got %h want 140", bk_rd_addr); end
      @(posedge clk); #1;
      req = '0;
      total++; if (bk_vld !== 4'b0100) begin bad++; $display("FAIL single_vld: got %b want 0100", bk_vld); end
      total++; if (bk_ocid[8:6] !== 3'd3) begin bad++; $display("FAIL single_ocid: got %0d want 3", bk_ocid[8:6]); end
      $display("test_single_read done");
   endtask

   task automatic test_conflict();
      int exp_s [4];
      logic [2:0] exp_row;
`ifdef OC_ARB_RR_EN
      exp_s = '{0, 2, 5, 0};
`else
      exp_s = '{0, 0, 0, 0};
`endif
      do_reset();
      set_slot(0, 2'd1, 3'd1);
      set_slot(2, 2'd1, 3'd2);
      set_slot(5, 2'd1, 3'd3);
      req = 8'h25;
      for (int i = 0; i < 4; i++) begin
         exp_row = (exp_s[i] == 0) ? 3'd1 : (exp_s[i] == 2) ? 3'd2 : 3'd3;
         #1;
         total++; if (gnt !== (8'd1 << exp_s[i])) begin
            bad++; $display("FAIL conflict_gnt%0d: got %h want %h", i, gnt, 8'd1 << exp_s[i]);
         end
         total++; if (bk_rd_addr[5:3] !== exp_row) begin
            bad++; $display("FAIL conflict_row%0d: got %0d want %0d", i, bk_rd_addr[5:3], exp_row);
         end
         @(posedge clk); #1;
         total++; if (bk_ocid[5:3] !== 3'(exp_s[i])) begin
            bad++; $display("FAIL conflict_ocid%0d: got %0d want %0d", i, bk_ocid[5:3], exp_s[i]);
         end
      end
      req = '0;
      total++; if (conflict_cnt[31:16] !== 16'd4) begin
         bad++; $display("FAIL conflict_cnt: got %0d want 4", conflict_cnt[31:16]);
      end
      total++; if (conflict_cnt[15:0] !== 16'd0) begin
         bad++; $display("FAIL conflict_cnt_b0: got %0d want 0", conflict_cnt[15:0]);
      end
      $display("test_conflict done");
   endtask

   task automatic test_wb_stall();
      do_reset();
      set_slot(1, 2'd0, 3'd7);
      req = 8'h02;
      wb_bank_busy = 4'b0001;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (gnt !== 8'h00) begin bad++; $display("FAIL stall_gnt%0d: got %h want 00", i, gnt); end
         total++; if (bk_rd_en !== 4'h0) begin bad++; $display("FAIL stall_rd_en%0d: got %b want 0000", i, bk_rd_en); end
         @(posedge clk); #1;
         total++; if (bk_bz !== 4'b0001) begin bad++; $display("FAIL stall_bz%0d: got %b want 0001", i, bk_bz); end
         total++; if (bk_vld !== 4'b0000) begin bad++; $display("FAIL stall_vld%0d: got %b want 0000", i, bk_vld); end
      end
      wb_bank_busy = 4'b0000;
      #1;
      total++; if (gnt !== 8'h02) begin bad++; $display("FAIL stall_release_gnt: got %h want 02", gnt); end
      total++; if (bk_rd_addr !== 12'h007) begin bad++; $display("FAIL stall_release_addr: got %h want 007", bk_rd_addr); end
      @(posedge clk); #1;
      req = '0;
      total++; if (bk_vld !== 4'b0001) begin bad++; $display("FAIL stall_release_vld: got %b want 0001", bk_vld); end
      total++; if (bk_bz !== 4'b0000) begin bad++; $display("FAIL stall_release_bz: got %b want 0000", bk_bz); end
      total++; if (bk_ocid[2:0] !== 3'd1) begin bad++; $display("FAIL stall_release_ocid: got %0d want 1", bk_ocid[2:0]); end
      $display("test_wb_stall done");
   endtask

   task automatic test_parallel_clear();
      do_reset();
      set_slot(0, 2'd0, 3'd0);
      set_slot(2, 2'd1, 3'd1);
      set_slot(4, 2'd2, 3'd2);
      set_slot(6, 2'd3, 3'd3);
      req = 8'h55;
      oc_clr = 4'b1000;
      #1;
      total++; if (gnt !== 8'h15) begin bad++; $display("FAIL par_gnt: got %h want 15", gnt); end
      total++; if (bk_rd_en !== 4'b0111) begin bad++; $display("FAIL par_rd_en: got %b want 0111", bk_rd_en); end
      @(posedge clk); #1;
      total++; if (bk_vld !== 4'b0111) begin bad++; $display("FAIL par_vld: got %b want 0111", bk_vld); end
      oc_clr = 4'b0100;
      #1;
      total++; if (gnt !== 8'h45) begin bad++; $display("FAIL par_clr2_gnt: got %h want 45", gnt); end
      @(posedge clk); #1;
      req = '0; oc_clr = '0;
      total++; if (bk_vld !== 4'b1011) begin bad++; $display("FAIL par_clr2_vld: got %b want 1011", bk_vld); end
      total++; if (bk_ocid !== 12'hD10) begin bad++; $display("FAIL par_clr2_ocid: got %h want d10", bk_ocid); end
      $display("test_parallel_clear done");
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int s = 0; s < 4; s++) set_slot(s, 2'(s), 3'(s));
      req = 8'h0F;
      @(posedge clk); #1;
      total++; if (bk_vld !== 4'hF) begin bad++; $display("FAIL arst_pre_vld: got %h want f", bk_vld); end
      #2;
      rst = 1'b0;
      #1;
      total++; if (bk_vld !== 4'h0) begin bad++; $display("FAIL arst_vld: got %h want 0", bk_vld); end
      total++; if (bk_ocid !== 12'h0) begin bad++; $display("FAIL arst_ocid: got %h want 0", bk_ocid); end
      @(posedge clk); #1;
      req = '0;
      // Bank 0 pointer was 1 before reset; slot 4 would win if it were kept.
      set_slot(4, 2'd0, 3'd6);
      req = 8'h11;
      rst = 1'b1;
      #1;
      total++; if (gnt !== 8'h01) begin bad++; $display("FAIL arst_ptr_gnt: got %h want 01", gnt); end
      @(posedge clk); #1;
      req = '0;
      total++; if (bk_ocid[2:0] !== 3'd0) begin bad++; $display("FAIL arst_ptr_ocid: got %0d want 0", bk_ocid[2:0]); end
      $display("test_async_reset done");
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_conflict();
      test_wb_stall();
      test_parallel_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
